// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB master: FSM state encoding,
// default UART register map, status bit positions and APB bus widths.
package uart_apb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] STAT_ADDR_DEF = 4'h0;
  localparam logic [ADDR_W-1:0] TX_ADDR_DEF   = 4'h4;
  localparam logic [ADDR_W-1:0] RX_ADDR_DEF   = 4'h8;

  localparam int STAT_RXEMPTY_BIT_DEF = 0;
  localparam int STAT_TXFULL_BIT_DEF  = 1;

  typedef enum logic [2:0] {
    IDLE,
    STAT_SETUP,
    STAT_ACCESS,
    DECIDE,
    WR_SETUP,
    WR_ACCESS,
    RD_SETUP,
    RD_ACCESS
  } state_e;

endpackage

// File: rtl/uart_apb_byte_hold.sv
// One-entry valid/ready byte holding register, used for both the TX and RX
// paths of the UART APB master.
module uart_apb_byte_hold (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       clear_i,
  output logic       valid_o,
  output logic [7:0] data_o
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  // Data only moves on a load, so it stays stable while the entry waits.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/uart_apb_master.sv
// APB master that polls the UART status register and moves bytes between the
// TX/RX byte streams and the UART data registers. Define
// UART_APB_MASTER_STATS_EN to add saturating TX/RX transfer counters.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] STAT_ADDR        = STAT_ADDR_DEF,
  parameter logic [ADDR_W-1:0] TX_ADDR          = TX_ADDR_DEF,
  parameter logic [ADDR_W-1:0] RX_ADDR          = RX_ADDR_DEF,
  parameter int                STAT_RXEMPTY_BIT = STAT_RXEMPTY_BIT_DEF,
  parameter int                STAT_TXFULL_BIT  = STAT_TXFULL_BIT_DEF,
  parameter int                POLL_CYCLES      = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tx_valid_i,
  input  logic [7:0]        tx_data_i,
  output logic              tx_ready_o,
  output logic              rx_valid_o,
  output logic [7:0]        rx_data_o,
  input  logic              rx_ready_i,
  input  logic              uart_int_i,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  input  logic [DATA_W-1:0] prdata_i
`ifdef UART_APB_MASTER_STATS_EN
  ,
  output logic [15:0]       tx_count_o,
  output logic [15:0]       rx_count_o
`endif
);

  localparam int POLL_W = $clog2(POLL_CYCLES);
  localparam logic [POLL_W-1:0] POLL_RELOAD = POLL_W'(POLL_CYCLES - 1);

  state_e              state_q, state_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic                rx_first_q, rx_first_d;
  logic [DATA_W-1:0]   stat_q, stat_d;

  logic                tx_full;
  logic [7:0]          tx_byte;
  logic                poll_trigger;
  logic                rx_go, tx_go;

  // Only the two status flags are acted on; the rest of the word is kept for visibility.
  logic                unused_stat_bits;
  assign unused_stat_bits = ^stat_q;

  uart_apb_byte_hold u_tx_hold (
    .clk     (clk),
    .rstn    (rstn),
    .load_i  (tx_valid_i & tx_ready_o),
    .data_i  (tx_data_i),
    .clear_i (state_q == WR_ACCESS),
    .valid_o (tx_full),
    .data_o  (tx_byte)
  );

  uart_apb_byte_hold u_rx_hold (
    .clk     (clk),
    .rstn    (rstn),
    .load_i  (state_q == RD_ACCESS),
    .data_i  (prdata_i[7:0]),
    .clear_i (rx_valid_o & rx_ready_i),
    .valid_o (rx_valid_o),
    .data_o  (rx_data_o)
  );

  assign tx_ready_o   = !tx_full;
  assign poll_trigger = tx_full || (!rx_valid_o && (uart_int_i || (poll_q == '0)));
  assign rx_go        = !stat_q[STAT_RXEMPTY_BIT] && !rx_valid_o;
  assign tx_go        = !stat_q[STAT_TXFULL_BIT] && tx_full;
  assign stat_d       = (state_q == STAT_ACCESS) ? prdata_i : stat_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      poll_q     <= POLL_RELOAD;
      rx_first_q <= 1'b1;
      stat_q     <= '0;
    end else begin
      state_q    <= state_d;
      poll_q     <= poll_d;
      rx_first_q <= rx_first_d;
      stat_q     <= stat_d;
    end
  end

  // When both directions are ready the fairness flag picks one and then flips.
  always_comb begin
    state_d    = state_q;
    poll_d     = poll_q;
    rx_first_d = rx_first_q;
    case (state_q)
      IDLE: begin
        if (poll_trigger) begin
          state_d = STAT_SETUP;
          poll_d  = POLL_RELOAD;
        end else if (poll_q != '0) begin
          poll_d = poll_q - POLL_W'(1);
        end
      end
      STAT_SETUP:  state_d = STAT_ACCESS;
      STAT_ACCESS: state_d = DECIDE;
      DECIDE: begin
        if (rx_go && tx_go) begin
          state_d    = rx_first_q ? RD_SETUP : WR_SETUP;
          rx_first_d = !rx_first_q;
        end else if (rx_go) begin
          state_d = RD_SETUP;
        end else if (tx_go) begin
          state_d = WR_SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      WR_SETUP:  state_d = WR_ACCESS;
      RD_SETUP:  state_d = RD_ACCESS;
      WR_ACCESS: state_d = IDLE;
      RD_ACCESS: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_o    = 1'b0;
    penable_o = 1'b0;
    pwrite_o  = 1'b0;
    paddr_o   = '0;
    pwdata_o  = '0;
    case (state_q)
      STAT_SETUP, STAT_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = (state_q == STAT_ACCESS);
        paddr_o   = STAT_ADDR;
      end
      WR_SETUP, WR_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = (state_q == WR_ACCESS);
        pwrite_o  = 1'b1;
        paddr_o   = TX_ADDR;
        pwdata_o  = {{(DATA_W-8){1'b0}}, tx_byte};
      end
      RD_SETUP, RD_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = (state_q == RD_ACCESS);
        paddr_o   = RX_ADDR;
      end
      default: ;
    endcase
  end

`ifdef UART_APB_MASTER_STATS_EN
  logic [15:0] tx_count_q, tx_count_d;
  logic [15:0] rx_count_q, rx_count_d;

  always_comb begin
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    if (state_q == WR_ACCESS && tx_count_q != 16'hFFFF) begin
      tx_count_d = tx_count_q + 16'd1;
    end
    if (state_q == RD_ACCESS && rx_count_q != 16'hFFFF) begin
      rx_count_d = rx_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_count_q <= 16'h0000;
      rx_count_q <= 16'h0000;
    end else begin
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign tx_count_o = tx_count_q;
  assign rx_count_o = rx_count_q;
`endif

endmodule

// File: tb/tb_uart_apb_master.sv
// Self-checking bench for uart_apb_master: directed scenarios followed by a
// randomized run against a byte-queue model of the UART register slave.
module tb_uart_apb_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        txValid;
  logic [7:0]  txData;
  logic        txReady;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        rxReady;
  logic        uartInt;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] prdata;
`ifdef UART_APB_MASTER_STATS_EN
  logic [15:0] txCount;
  logic [15:0] rxCount;
`endif

  logic [31:0] statusVal;
  logic [7:0]  rxHead;

  int          assertCount = 0;
  int          failCount   = 0;
  int          wrCount     = 0;
  int          rdCount     = 0;
  logic [31:0] lastWrData  = 32'h0;
  logic [7:0]  opLog[$];

  logic        modelOn = 1'b0;
  logic [7:0]  txPending[$];
  logic [7:0]  rxFifo[$];
  logic [7:0]  rxExp[$];
  logic [31:0] lastStat = 32'hFFFF_FFFF;
  int          rndSent = 0, rndWrites = 0, rndReads = 0, rndConsumed = 0, rndPushed = 0;

  logic        prevSel = 1'b0, prevSetup = 1'b0, prevWrite = 1'b0, prevRstn = 1'b0;
  logic [3:0]  prevAddr = 4'h0;
  logic [31:0] prevWdata = 32'h0;

  always #5 clk = ~clk;

  // The UART register slave answers combinationally from the bench-owned values.
  assign prdata = (paddr == 4'h0) ? statusVal :
                  (paddr == 4'h8) ? {24'h0, rxHead} : 32'h0;

  uart_apb_master dut (
    .clk        (clk),
    .rstn       (rstn),
    .tx_valid_i (txValid),
    .tx_data_i  (txData),
    .tx_ready_o (txReady),
    .rx_valid_o (rxValid),
    .rx_data_o  (rxData),
    .rx_ready_i (rxReady),
    .uart_int_i (uartInt),
    .paddr_o    (paddr),
    .pwdata_o   (pwdata),
    .psel_o     (psel),
    .penable_o  (penable),
    .pwrite_o   (pwrite),
    .prdata_i   (prdata)
`ifdef UART_APB_MASTER_STATS_EN
    ,
    .tx_count_o (txCount),
    .rx_count_o (rxCount)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, checks APB framing, books completed events, then steps a clock.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rr, input logic ui);
    logic ok, setupNow, accessNow;
    txValid = v;
    txData  = d;
    rxReady = rr;
    uartInt = ui;
    #1;
    setupNow  = psel && !penable;
    accessNow = psel && penable;
    ok = 1'b1;
    if (penable && !psel) ok = 1'b0;
    if (!psel && (pwrite || paddr != 4'h0 || pwdata != 32'h0)) ok = 1'b0;
    if (accessNow && !(prevSetup && paddr == prevAddr && pwrite == prevWrite && pwdata == prevWdata)) ok = 1'b0;
    if (setupNow && prevSel) ok = 1'b0;
    if (prevSetup && prevRstn && !accessNow) ok = 1'b0;
    checkOutput("apb_protocol", {31'h0, ok}, 32'h1);

    if (rstn) begin
      if (v && txReady && modelOn) begin
        txPending.push_back(d);
        rndSent++;
      end
      if (rxValid && rr && modelOn) begin
        checkOutput("rnd_rx_data", {24'h0, rxData}, (rxExp.size() != 0) ? {24'h0, rxExp[0]} : 32'hDEAD);
        if (rxExp.size() != 0) void'(rxExp.pop_front());
        rndConsumed++;
      end
      if (accessNow) begin
        if (pwrite) begin
          wrCount++;
          lastWrData = pwdata;
          opLog.push_back(8'h57);
          checkOutput("wr_addr", {28'h0, paddr}, 32'h4);
          if (modelOn) begin
            checkOutput("rnd_wr_allowed", {31'h0, lastStat[1]}, 32'h0);
            checkOutput("rnd_wr_data", pwdata, (txPending.size() != 0) ? {24'h0, txPending[0]} : 32'hFFFF_FFFF);
            if (txPending.size() != 0) void'(txPending.pop_front());
            rndWrites++;
          end
        end else if (paddr == 4'h0) begin
          lastStat = prdata;
        end else begin
          rdCount++;
          opLog.push_back(8'h52);
          checkOutput("rd_addr", {28'h0, paddr}, 32'h8);
          if (modelOn) begin
            checkOutput("rnd_rd_allowed", {31'h0, lastStat[0]}, 32'h0);
            if (rxFifo.size() != 0) rxExp.push_back(rxFifo.pop_front());
            rndReads++;
          end
        end
      end
    end else begin
      txPending.delete();
      rxExp.delete();
    end

    prevSel   = psel;
    prevSetup = setupNow;
    prevWrite = pwrite;
    prevAddr  = paddr;
    prevWdata = pwdata;
    prevRstn  = rstn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wrBefore, rdBefore, base;
    logic txFullBit;
    logic [7:0] firstOp, secondOp;

    rstn = 1'b0; txValid = 1'b0; txData = 8'h00; rxReady = 1'b0; uartInt = 1'b0;
    statusVal = 32'h1; rxHead = 8'h00;
    @(posedge clk);
    #1;

    $display("[TB] reset");
    applyStimulus(0, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("rst_apb_ctrl", {29'h0, psel, penable, pwrite}, 32'h0);
    checkOutput("rst_paddr", {28'h0, paddr}, 32'h0);
    checkOutput("rst_pwdata", pwdata, 32'h0);
    checkOutput("rst_streams", {22'h0, txReady, rxValid, rxData}, {22'h0, 1'b1, 1'b0, 8'h00});
    rstn = 1'b1;

    $display("[TB] tx write latency");
    checkOutput("tx_c0_ready", {31'h0, txReady}, 32'h1);
    applyStimulus(1, 8'hA5, 0, 0);
    checkOutput("tx_c1_state", {27'h0, txReady, psel, penable, pwrite, 1'b0}, 32'h0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("tx_c2_stat_setup", {25'h0, psel, penable, pwrite, paddr}, {25'h0, 3'b100, 4'h0});
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("tx_c3_stat_access", {25'h0, psel, penable, pwrite, paddr}, {25'h0, 3'b110, 4'h0});
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("tx_c4_decide", {31'h0, psel}, 32'h0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("tx_c5_wr_setup", {25'h0, psel, penable, pwrite, paddr}, {25'h0, 3'b101, 4'h4});
    checkOutput("tx_c5_pwdata", pwdata, 32'h0000_00A5);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("tx_c6_wr_access", {25'h0, psel, penable, pwrite, paddr}, {25'h0, 3'b111, 4'h4});
    checkOutput("tx_c6_ready", {31'h0, txReady}, 32'h0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("tx_c7_ready", {30'h0, txReady, psel}, 32'h2);

    $display("[TB] tx backpressure");
    statusVal = 32'h3;
    wrBefore = wrCount;
    applyStimulus(1, 8'h5A, 0, 0);
    for (int i = 0; i < 24; i++) applyStimulus(0, 8'h00, 0, 0);
    checkOutput("bp_no_write", wrCount - wrBefore, 0);
    checkOutput("bp_ready_low", {31'h0, txReady}, 32'h0);
    statusVal = 32'h1;
    for (int i = 0; i < 16 && wrCount == wrBefore; i++) applyStimulus(0, 8'h00, 0, 0);
    checkOutput("bp_write_seen", wrCount - wrBefore, 1);
    checkOutput("bp_write_data", lastWrData, 32'h0000_005A);
    checkOutput("bp_ready_back", {31'h0, txReady}, 32'h1);

    $display("[TB] rx read");
    statusVal = 32'h0;
    rxHead = 8'h3C;
    rdBefore = rdCount;
    for (int i = 0; i < 12 && !rxValid; i++) applyStimulus(0, 8'h00, 0, 1);
    checkOutput("rx_read_seen", rdCount - rdBefore, 1);
    checkOutput("rx_data", {23'h0, rxValid, rxData}, {23'h0, 1'b1, 8'h3C});
    rxHead = 8'h77;
    for (int i = 0; i < 20; i++) applyStimulus(0, 8'h00, 0, 1);
    checkOutput("rx_hold_no_read", rdCount - rdBefore, 1);
    checkOutput("rx_hold_stable", {23'h0, rxValid, rxData}, {23'h0, 1'b1, 8'h3C});

    $display("[TB] fairness");
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("rx_consumed", {31'h0, rxValid}, 32'h0);
    rxHead = 8'h11;
    base = opLog.size();
    wrBefore = wrCount;
    applyStimulus(1, 8'hC3, 1, 0);
    for (int i = 0; i < 40 && wrCount == wrBefore; i++) applyStimulus(0, 8'h00, 1, 0);
    firstOp  = (opLog.size() > base) ? opLog[base] : 8'h00;
    secondOp = (opLog.size() > base + 1) ? opLog[base + 1] : 8'h00;
    checkOutput("fair_order", {16'h0, firstOp, secondOp}, {16'h0, 8'h52, 8'h57});
    checkOutput("fair_wr_data", lastWrData, 32'h0000_00C3);

    $display("[TB] reset mid-transfer");
    statusVal = 32'h1;
    applyStimulus(1, 8'h99, 1, 0);
    for (int i = 0; i < 12 && !(psel && !penable && pwrite); i++) applyStimulus(0, 8'h00, 1, 0);
    checkOutput("rstmid_wr_setup", {29'h0, psel, penable, pwrite}, 32'h5);
    wrBefore = wrCount;
    rstn = 1'b0;
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("rstmid_after", {30'h0, psel, txReady}, 32'h1);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(0, 8'h00, 1, 0);
    checkOutput("rstmid_discard", wrCount - wrBefore, 0);

    $display("[TB] randomized run");
    rstn = 1'b0;
    applyStimulus(0, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    rstn = 1'b1;
    modelOn = 1'b1;
    txPending.delete();
    rxExp.delete();
    rxFifo.delete();
    lastStat = 32'hFFFF_FFFF;
    txFullBit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0 && rxFifo.size() < 8) begin
        rxFifo.push_back(8'($urandom));
        rndPushed++;
      end
      if ($urandom_range(0, 7) == 0) txFullBit = ~txFullBit;
      statusVal = {30'($urandom), txFullBit, rxFifo.size() == 0};
      rxHead = (rxFifo.size() != 0) ? rxFifo[0] : 8'h00;
      checkOutput("rnd_tx_ready", {31'h0, txReady}, {31'h0, txPending.size() == 0});
      checkOutput("rnd_rx_valid", {31'h0, rxValid}, {31'h0, rxExp.size() != 0});
      applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom_range(0, 1)),
                    (rxFifo.size() != 0) && ($urandom_range(0, 1) == 1));
    end

    txFullBit = 1'b0;
    for (int i = 0; i < 3000 && !(txPending.size() == 0 && rxFifo.size() == 0 && rxExp.size() == 0); i++) begin
      statusVal = {30'h0, txFullBit, rxFifo.size() == 0};
      rxHead = (rxFifo.size() != 0) ? rxFifo[0] : 8'h00;
      applyStimulus(0, 8'h00, 1, rxFifo.size() != 0);
    end
    checkOutput("rnd_drained", {29'h0, txPending.size() == 0, rxFifo.size() == 0, rxExp.size() == 0}, 32'h7);
    checkOutput("rnd_tx_total", rndWrites, rndSent);
    checkOutput("rnd_rx_total", rndConsumed, rndPushed);
    checkOutput("rnd_rx_reads", rndReads, rndPushed);
`ifdef UART_APB_MASTER_STATS_EN
    checkOutput("stats_tx", {16'h0, txCount}, rndWrites);
    checkOutput("stats_rx", {16'h0, rxCount}, rndReads);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
